// File: rtl/cordic_info_stage_unit.sv
// One registered rotation-mode CORDIC micro-rotation by +/-atan(2^-i).
// The target, valid flag and float side-band word travel alongside with matching latency.
module cordic_info_stage_unit #(
  parameter int unsigned INTEGER_WIDTH    = 2,
  parameter int unsigned FRACTIONAL_WIDTH = 20,
  parameter int unsigned SHIFT_WIDTH      = 4,
  parameter int unsigned FLOAT_DATA_WIDTH = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              clk_en,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         target,
  input  logic                                              valid_in,
  input  logic [FLOAT_DATA_WIDTH-1:0]                       squared_in,
  input  logic [SHIFT_WIDTH-1:0]                            shift_value,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         shift_angle,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         angle,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         x,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         y,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         new_angle,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         new_x,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         new_y,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0]         target_out,
  output logic                                              valid_out,
  output logic [FLOAT_DATA_WIDTH-1:0]                       squared_out
);

  localparam int unsigned DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;

  logic                         rot_pos;
  logic signed [DATA_WIDTH-1:0] xs;
  logic signed [DATA_WIDTH-1:0] ys;

  logic [DATA_WIDTH-1:0]       new_x_d,     new_x_q;
  logic [DATA_WIDTH-1:0]       new_y_d,     new_y_q;
  logic [DATA_WIDTH-1:0]       new_angle_d, new_angle_q;
  logic [DATA_WIDTH-1:0]       target_q;
  logic                        valid_q;
  logic [FLOAT_DATA_WIDTH-1:0] squared_q;

  // Rotate toward the target; a tie rotates positively. Both shifts use pre-update x/y.
  always_comb begin
    rot_pos     = ($signed(target) >= $signed(angle));
    xs          = $signed(x) >>> shift_value;
    ys          = $signed(y) >>> shift_value;
    new_x_d     = x;
    new_y_d     = y;
    new_angle_d = angle;
    if (rot_pos) begin
      new_x_d     = x - DATA_WIDTH'(ys);
      new_y_d     = y + DATA_WIDTH'(xs);
      new_angle_d = angle + shift_angle;
    end else begin
      new_x_d     = x + DATA_WIDTH'(ys);
      new_y_d     = y - DATA_WIDTH'(xs);
      new_angle_d = angle - shift_angle;
    end
  end

  // Data is registered every enabled cycle; valid only qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_x_q     <= '0;
      new_y_q     <= '0;
      new_angle_q <= '0;
      target_q    <= '0;
      valid_q     <= 1'b0;
      squared_q   <= '0;
    end else if (clk_en) begin
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      new_angle_q <= new_angle_d;
      target_q    <= target;
      valid_q     <= valid_in;
      squared_q   <= squared_in;
    end
  end

  assign new_x       = new_x_q;
  assign new_y       = new_y_q;
  assign new_angle   = new_angle_q;
  assign target_out  = target_q;
  assign valid_out   = valid_q;
  assign squared_out = squared_q;

endmodule

// File: tb/tb_cordic_info_stage_unit.sv
// Directed and random checks of one CORDIC stage against an integer reference model.
module tb_cordic_info_stage_unit;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [21:0] target;
  logic        valid_in;
  logic [31:0] squared_in;
  logic [3:0]  shift_value;
  logic [21:0] shift_angle;
  logic [21:0] angle;
  logic [21:0] x;
  logic [21:0] y;
  logic [21:0] new_angle;
  logic [21:0] new_x;
  logic [21:0] new_y;
  logic [21:0] target_out;
  logic        valid_out;
  logic [31:0] squared_out;

  typedef struct {
    logic [21:0] nx;
    logic [21:0] ny;
    logic [21:0] na;
    logic [21:0] tgt;
    logic        v;
    logic [31:0] sq;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_chk;
  int   n_pass;

  cordic_info_stage_unit dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .target      (target),
    .valid_in    (valid_in),
    .squared_in  (squared_in),
    .shift_value (shift_value),
    .shift_angle (shift_angle),
    .angle       (angle),
    .x           (x),
    .y           (y),
    .new_angle   (new_angle),
    .new_x       (new_x),
    .new_y       (new_y),
    .target_out  (target_out),
    .valid_out   (valid_out),
    .squared_out (squared_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sext(input logic [21:0] v);
    return int'({{10{v[21]}}, v});
  endfunction

  // Floor division by 2^s, i.e. the value of a sign-preserving right shift.
  function automatic int floor_div(input int v, input int s);
    int p;
    p = 1 << s;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  function automatic exp_t model(input logic [21:0] xi, input logic [21:0] yi,
                                 input logic [21:0] ai, input logic [21:0] ti,
                                 input logic [3:0] sh, input logic [21:0] sa,
                                 input logic vi, input logic [31:0] sqi);
    exp_t e;
    int xv, yv, av, tv, xsv, ysv, sav, d;
    xv  = sext(xi);
    yv  = sext(yi);
    av  = sext(ai);
    tv  = sext(ti);
    sav = sext(sa);
    xsv = floor_div(xv, int'(sh));
    ysv = floor_div(yv, int'(sh));
    d   = (tv >= av) ? 1 : -1;
    e.nx  = 22'(xv - d * ysv);
    e.ny  = 22'(yv + d * xsv);
    e.na  = 22'(av + d * sav);
    e.tgt = ti;
    e.v   = vi;
    e.sq  = sqi;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drive one enabled sample at the falling edge and queue its expected result.
  task automatic drive(input logic [21:0] xi, input logic [21:0] yi, input logic [21:0] ai,
                       input logic [21:0] ti, input logic [3:0] sh, input logic [21:0] sa,
                       input logic vi, input logic [31:0] sqi);
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b1;
    x = xi; y = yi; angle = ai; target = ti; shift_value = sh; shift_angle = sa;
    valid_in = vi; squared_in = sqi;
    sb.push_back(model(xi, yi, ai, ti, sh, sa, vi, sqi));
  endtask

  // Disabled cycle with scrambled inputs: outputs must hold.
  task automatic drive_hold();
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b0;
    x = 22'($urandom); y = 22'($urandom); angle = 22'($urandom); target = 22'($urandom);
    shift_value = 4'($urandom); shift_angle = 22'($urandom);
    valid_in = 1'($urandom); squared_in = $urandom;
    sb.push_back(last_exp);
  endtask

  task automatic drive_reset(input logic en);
    exp_t z;
    z = '{22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0};
    @(negedge clk);
    rst = 1'b1; clk_en = en;
    x = 22'($urandom); y = 22'($urandom); valid_in = 1'b1; squared_in = $urandom;
    sb.push_back(z);
  endtask

  task automatic check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      cmp({tag, "_queue"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      last_exp = e;
      cmp({tag, "_new_x"},     32'(new_x),       32'(e.nx));
      cmp({tag, "_new_y"},     32'(new_y),       32'(e.ny));
      cmp({tag, "_new_angle"}, 32'(new_angle),   32'(e.na));
      cmp({tag, "_target"},    32'(target_out),  32'(e.tgt));
      cmp({tag, "_valid"},     32'(valid_out),   32'(e.v));
      cmp({tag, "_squared"},   squared_out,      e.sq);
    end
  endtask

  initial begin
    int pat[4];
    n_chk = 0;
    n_pass = 0;
    pat = '{1, 0, 1, 1};
    last_exp = '{22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0};
    rst = 1'b1; clk_en = 1'b0; target = '0; valid_in = 1'b0; squared_in = '0;
    shift_value = '0; shift_angle = '0; angle = '0; x = '0; y = '0;

    // Reset with enable high must still clear.
    drive_reset(1'b1);
    check("reset");

    drive(22'h09B74E, 22'h000000, 22'h000000, 22'h080000, 4'd0, 22'h0C90FD, 1'b1, 32'h3E800000);
    check("step0");
    cmp("step0_x_const", 32'(new_x), 32'h0009B74E);
    cmp("step0_y_const", 32'(new_y), 32'h0009B74E);
    cmp("step0_a_const", 32'(new_angle), 32'h000C90FD);

    // Over-rotated: direction flips negative.
    drive(22'h09B74E, 22'h09B74E, 22'h0C90FD, 22'h080000, 4'd1, 22'h076B19, 1'b1, 32'h3F000000);
    check("negstep");
    cmp("negstep_a_const", 32'(new_angle), 32'h000525E4);

    drive(22'h000010, 22'h3FFFF8, 22'h000000, 22'h000000, 4'd2, 22'h03EB6E, 1'b1, 32'h12345678);
    check("ashift");
    cmp("ashift_x_const", 32'(new_x), 32'h00000012);
    cmp("ashift_y_const", 32'(new_y), 32'h003FFFFC);

    drive(22'h000123, 22'h3FF000, 22'h1FFFFF, 22'h1FFFFF, 4'd15, 22'h000001, 1'b1, 32'hCAFEF00D);
    check("wrap");
    cmp("wrap_a_const", 32'(new_angle), 32'h00200000);

    drive(22'h3C0000, 22'h250000, 22'h100000, 22'h2F0000, 4'd3, 22'h01FD5B, 1'b1, 32'hDEADBEEF);
    check("hold_src");
    for (int i = 0; i < 3; i++) begin
      drive_hold();
      check("hold");
    end
    drive_reset(1'b0);
    check("rst_noen");

    for (int i = 0; i < 4; i++) begin
      drive(22'($urandom), 22'($urandom), 22'($urandom), 22'($urandom),
            4'($urandom), 22'($urandom_range(22'h0C90FD)), 1'(pat[i]), $urandom);
      check("stream");
    end

    for (int i = 0; i < 16; i++) begin
      drive(22'($urandom), 22'($urandom), 22'($urandom), 22'($urandom),
            4'(i), 22'($urandom_range(22'h0C90FD)), 1'($urandom), $urandom);
      check("random");
    end

    cmp("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
